// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, 1-cycle-latency memory between instruction fetch and data access.
// Data wins by default; a saturating streak counter forces a fetch grant after MAX_DATA_STREAK data wins.
module mem_arbiter #(
  parameter int WORD_LEN        = 32,
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  input  logic                i_kill,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic [WORD_LEN-1:0] m_addr,
  output logic                m_wen,
  output logic [WORD_LEN-1:0] m_wdata,
  input  logic [WORD_LEN-1:0] m_rdata
);
  localparam logic [3:0] MaxStreak = 4'(MAX_DATA_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       pend_i_q, pend_i_d;
  logic       pend_d_q, pend_d_d;
  logic       force_i;

  always_comb begin
    force_i = i_req && (streak_q == MaxStreak);
    d_gnt   = !rst && d_req && !force_i;
    i_gnt   = !rst && i_req && (!d_req || force_i);
    m_addr  = d_gnt ? d_addr : i_addr;
    m_wen   = d_gnt && d_we;
    m_wdata = d_wdata;
  end

  // Kill is applied at the output, in the cycle the fetch response is due.
  always_comb begin
    pend_i_d = i_gnt;
    pend_d_d = d_gnt && !d_we;
    streak_d = streak_q;
    if (i_gnt || !i_req)
      streak_d = '0;
    else if (d_gnt && streak_q != MaxStreak)
      streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
    end
  end

  // A response landing while rst is high is dropped.
  assign i_rvalid = pend_i_q && !i_kill && !rst;
  assign d_rvalid = pend_d_q && !rst;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-read memory model attached.
module tb_mem_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, i_kill, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  logic         i_gnt, i_rvalid, d_gnt, d_rvalid, m_wen;
  logic [W-1:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [W-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WORD_LEN(W), .MAX_DATA_STREAK(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded during reset, write-then-registered-read.
  always @(posedge clk) begin
    if (rst) begin
      mem[0]  <= 32'h0000_0013;
      mem[1]  <= 32'h0050_0093;
      mem[2]  <= 32'h0010_0113;
      mem[8]  <= 32'hAAAA_0020;
      mem[16] <= 32'h0BAD_F00D;
    end else if (m_wen) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
    m_rdata <= mem[m_addr[9:2]];
  end

  task automatic idle();
    i_req = 0; d_req = 0; i_kill = 0; d_we = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; i_req = 1; d_req = 1; d_we = 1; i_kill = 0;
    i_addr = 0; d_addr = 32'h100; d_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL reset_i_gnt got %0b want 0", i_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %0b want 0", d_gnt); end
    checks++; if (m_wen !== 1'b0) begin errors++; $display("FAIL reset_m_wen got %0b want 0", m_wen); end
    @(negedge clk);
    rst = 0;
    idle();
  endtask

  task automatic test_fetch_stream();
    logic [W-1:0] exp [3];
    exp[0] = 32'h0000_0013; exp[1] = 32'h0050_0093; exp[2] = 32'h0010_0113;
    for (int c = 0; c < 4; c++) begin
      i_req = (c < 3); i_addr = 32'(c * 4); d_req = 0; i_kill = 0;
      #1;
      checks++;
      if (i_gnt !== (c < 3)) begin errors++; $display("FAIL fetch_gnt c=%0d got %0b want %0b", c, i_gnt, c < 3); end
      if (c > 0) begin
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== exp[c-1]) begin
          errors++; $display("FAIL fetch_rdata c=%0d got v=%0b %h want v=1 %h", c, i_rvalid, i_rdata, exp[c-1]);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_streak();
    logic exp_d [5];
    exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 0; exp_d[3] = 1; exp_d[4] = 1;
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h4; i_kill = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (d_gnt !== exp_d[c] || i_gnt !== !exp_d[c]) begin
        errors++; $display("FAIL streak_seq c=%0d got d=%0b i=%0b want d=%0b", c, d_gnt, i_gnt, exp_d[c]);
      end
      if (c == 2) begin
        checks++;
        if (m_addr !== 32'h8) begin errors++; $display("FAIL streak_maddr got %h want 00000008", m_addr); end
      end
      @(negedge clk);
    end
    idle();
    idle();
  endtask

  task automatic test_write_read();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; i_req = 0; i_kill = 0;
    #1;
    checks++;
    if (d_gnt !== 1 || m_wen !== 1 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_issue got gnt=%0b wen=%0b a=%h wd=%h want 1 1 100 deadbeef", d_gnt, m_wen, m_addr, m_wdata);
    end
    @(negedge clk);
    d_we = 0; d_wdata = 0;
    #1;
    checks++;
    if (d_gnt !== 1 || m_wen !== 0 || d_rvalid !== 0) begin
      errors++; $display("FAIL rd_issue got gnt=%0b wen=%0b rv=%0b want 1 0 0", d_gnt, m_wen, d_rvalid);
    end
    @(negedge clk);
    d_req = 0;
    #1;
    checks++;
    if (d_rvalid !== 1 || d_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_data got rv=%0b %h want 1 deadbeef", d_rvalid, d_rdata);
    end
    @(negedge clk);
    #1;
    checks++; if (d_rvalid !== 0) begin errors++; $display("FAIL rd_single got rv=%0b want 0", d_rvalid); end
    idle();
  endtask

  task automatic test_kill();
    i_req = 1; i_addr = 32'h20; d_req = 0; i_kill = 0;
    #1;
    checks++; if (i_gnt !== 1) begin errors++; $display("FAIL kill_gnt0 got %0b want 1", i_gnt); end
    @(negedge clk);
    i_addr = 32'h40; i_kill = 1;
    #1;
    checks++;
    if (i_rvalid !== 0 || i_gnt !== 1) begin
      errors++; $display("FAIL kill_drop got rv=%0b gnt=%0b want 0 1", i_rvalid, i_gnt);
    end
    @(negedge clk);
    i_req = 0; i_kill = 0;
    #1;
    checks++;
    if (i_rvalid !== 1 || i_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL kill_next got rv=%0b %h want 1 0badf00d", i_rvalid, i_rdata);
    end
    @(negedge clk);
    i_kill = 1;
    #1;
    checks++; if (i_rvalid !== 0) begin errors++; $display("FAIL kill_idle got rv=%0b want 0", i_rvalid); end
    idle();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 32'h100; i_req = 0; i_kill = 0;
    #1;
    checks++; if (d_gnt !== 1) begin errors++; $display("FAIL rstmid_gnt got %0b want 1", d_gnt); end
    @(negedge clk);
    rst = 1; i_req = 1; i_addr = 0;
    #1;
    checks++;
    if (d_rvalid !== 0 || d_gnt !== 0 || i_gnt !== 0) begin
      errors++; $display("FAIL rstmid_drop got rv=%0b d=%0b i=%0b want 0 0 0", d_rvalid, d_gnt, i_gnt);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (d_gnt !== 1 || i_gnt !== 0 || d_rvalid !== 0) begin
      errors++; $display("FAIL rstmid_after got d=%0b i=%0b rv=%0b want 1 0 0", d_gnt, i_gnt, d_rvalid);
    end
    @(negedge clk);
    idle();
    idle();
  endtask

  task automatic test_back_to_back();
    logic exp_i [3];
    exp_i[0] = 0; exp_i[1] = 0; exp_i[2] = 1;
    d_req = 1; d_we = 0; d_addr = 32'h0; i_req = 0; i_kill = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (d_gnt !== 1 || (c > 0 && d_rvalid !== 1)) begin
        errors++; $display("FAIL b2b_d c=%0d got gnt=%0b rv=%0b want 1 1", c, d_gnt, d_rvalid);
      end
      @(negedge clk);
    end
    i_req = 1; i_addr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (i_gnt !== exp_i[c] || d_gnt !== !exp_i[c]) begin
        errors++; $display("FAIL b2b_fetch c=%0d got i=%0b d=%0b want i=%0b", c, i_gnt, d_gnt, exp_i[c]);
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_streak();
    test_write_read();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
